lif_neuron_array: RTL
=====================

Name: lif_neuron_array

Overview:
- Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons sharing one leak/integrate/fire datapath.
- Membrane potentials live in an internal register array.
- A step strobe advances every neuron by one timestep, sequentially, one neuron per cycle.
- Generalised successor to the single-neuron LIF tile. Sits behind the tile top level, with ui_in/uio_in feeding currents and config, and uo_out carrying spikes.

Parameters:
- N_NEURONS, 4, neuron count (2..16).
- WIDTH, 8, membrane and current width, unsigned.
- LEAK_SHIFT, 3, shift amount for exponential leak mode.
- LEAK_CONST, 5, decrement per step for linear leak mode.
- REFRACT_STEPS, 2, refractory length in steps (only with REFRACTORY_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- step  in  1  one-cycle strobe: start one timestep for all neurons.
- in_current  in  N_NEURONS*WIDTH  input current; neuron k uses bits [k*WIDTH +: WIDTH].
- threshold  in  WIDTH  firing threshold.
- leak_mode  in  1  0 = exponential (shift) leak, 1 = linear leak.
- reset_mode  in  1  0 = reset to zero on spike, 1 = subtract threshold on spike.
- mem_sel  in  $clog2(N_NEURONS)  selects the neuron for mem_out.
- spikes  out  N_NEURONS  spike vector of the last completed step.
- done  out  1  one-cycle pulse when a step completes.
- busy  out  1  high while a step is in progress.
- mem_out  out  WIDTH  registered membrane potential of neuron mem_sel.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All membranes, spikes, done, busy and mem_out go to 0.
  - FSM goes to IDLE and the index goes to 0.
  - Reset mid-step aborts the step; no done pulse.
- FSM states: IDLE, UPDATE, DONE.
- IDLE, on step=1:
  - Latch in_current, threshold, leak_mode and reset_mode into shadow registers.
  - idx <= 0; busy <= 1; go to UPDATE.
- UPDATE (one neuron per cycle, neuron idx):
  - leak = v>>LEAK_SHIFT (mode 0), or min(v, LEAK_CONST) (mode 1).
  - s = (v - leak) + I, computed at WIDTH+1 bits, then saturated to 2^WIDTH-1.
  - If s >= threshold: spike_acc[idx] = 1; v <= 0 (reset_mode 0) or s - threshold (reset_mode 1).
  - Otherwise: spike_acc[idx] = 0; v <= s.
  - If idx == N_NEURONS-1, go to DONE; otherwise idx++.
- DONE (one cycle):
  - spikes <= spike_acc; done = 1; busy <= 0; go to IDLE.
  - spikes holds its value until the next DONE.
- Latency: step sampled at cycle 0 gives done high at cycle N_NEURONS+1.
  - Minimum step period is N_NEURONS+2 cycles.
- step while busy=1, or during the DONE cycle, is ignored. No queueing.
- Config and current changes mid-step have no effect (shadowed).
- threshold = 0: every updated neuron spikes every step.
- mem_out: registered each cycle from the array.
  - Reflects updates one cycle after the write.
  - mem_sel >= N_NEURONS returns 0.
- Arithmetic is unsigned. The leak never underflows, because leak <= v in both modes.

Optional Feature:
- Macro LIF_REFRACTORY_EN.
- Defined:
  - Each neuron has a refractory counter, $clog2(REFRACT_STEPS+1) bits wide.
  - A spike loads REFRACT_STEPS into the counter.
  - While the counter is nonzero, the neuron's update skips integration: v <= v - leak, no spike possible, and the counter decrements.
  - Counters reset to 0.
- Undefined: no counters; a neuron may spike on consecutive steps. All port behaviour is otherwise identical.

Test Plan:
- Reset:
  - Stimulus: rst high 2 cycles with step toggling.
  - Required: spikes=0, done=0, busy=0, mem_out=0 for every mem_sel.
- Exponential integrate and fire (N=4, WIDTH=8, LEAK_SHIFT=3, neuron 0):
  - Stimulus: I=0x40, threshold=0x80, modes 0/0; three steps.
  - Required: mem_out 64, then 120, then spike.
  - Step 3 sum is 169, so spikes=4'b0001 and v=0.
  - done arrives exactly 5 cycles after each step.
- Saturation and subtract-reset (neuron 2):
  - Stimulus: I=0xFF, v=0xF0, threshold=0xC8, reset_mode=1.
  - Required: s saturates to 255; spikes[2]=1; v=55.
- Linear leak floor:
  - Stimulus: leak_mode=1, LEAK_CONST=5, v=3, I=0.
  - Required: v=0, no spike.
  - Then I=2: v=2.
- Busy/abort:
  - Stimulus: second step 2 cycles after the first.
  - Required: ignored, single done pulse.
  - Stimulus: rst asserted at UPDATE idx=1.
  - Required: no done pulse; all membranes 0.
- LIF_REFRACTORY_EN (REFRACT_STEPS=2):
  - Stimulus: I=0xFF, threshold=0x80, reset_mode 0.
  - Required: spikes[0] pattern over 6 steps is 1,0,0,1,0,0.
  - Without the macro the pattern is 1,1,1,1,1,1.

Source files
------------

// File: rtl/lif_neuron_array_if.sv
// Bundle of step/config/current inputs and spike/status outputs for the
// time-multiplexed LIF neuron array. The master drives stimulus and the
// slave (the neuron array) returns spikes, status and membrane readback.
interface lif_neuron_array_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
);
  localparam int SEL_W = $clog2(N_NEURONS);

  logic                     step;
  logic [N_NEURONS*WIDTH-1:0] in_current;
  logic [WIDTH-1:0]         threshold;
  logic                     leak_mode;
  logic                     reset_mode;
  logic [SEL_W-1:0]         mem_sel;
  logic [N_NEURONS-1:0]     spikes;
  logic                     done;
  logic                     busy;
  logic [WIDTH-1:0]         mem_out;

  modport master (
    output step, in_current, threshold, leak_mode, reset_mode, mem_sel,
    input  spikes, done, busy, mem_out
  );

  modport slave (
    input  step, in_current, threshold, leak_mode, reset_mode, mem_sel,
    output spikes, done, busy, mem_out
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons. One shared
// leak/integrate/fire datapath walks the membrane array one neuron per
// cycle after each step strobe, then publishes the spike vector.
// Optional feature: define LIF_REFRACTORY_EN to give every neuron a
// refractory counter that suppresses integration for REFRACT_STEPS steps
// after each spike.
module lif_neuron_array #(
  parameter int N_NEURONS     = 4,
  parameter int WIDTH         = 8,
  parameter int LEAK_SHIFT    = 3,
  parameter int LEAK_CONST    = 5,
  parameter int REFRACT_STEPS = 2
) (
  input  logic              clk,
  input  logic              rst,
  lif_neuron_array_if.slave bus
);
  localparam int SEL_W = $clog2(N_NEURONS);
  localparam int RC_W  = $clog2(REFRACT_STEPS + 1);

  typedef logic [WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  // Reject configurations the index/counter widths cannot represent.
  generate
    if (N_NEURONS < 2 || N_NEURONS > 16 || REFRACT_STEPS < 1 || RC_W < 1) begin : g_bad_cfg
      $error("lif_neuron_array: unsupported parameter combination");
    end
  endgenerate

  // Leak amount; never exceeds v in either mode, so v - leak cannot wrap.
  function automatic word_t leak_of(input word_t v, input logic linear);
    word_t lc;
    lc = word_t'(LEAK_CONST);
    if (linear) return (v < lc) ? v : lc;
    else        return v >> LEAK_SHIFT;
  endfunction

  // Unsigned add clamped to the all-ones membrane ceiling.
  function automatic word_t sat_add(input word_t a, input word_t b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  endfunction

  state_t               state;
  logic [SEL_W-1:0]     idx;
  word_t                mem_v [N_NEURONS];
  logic [N_NEURONS-1:0] spike_acc;
  logic [N_NEURONS-1:0] spikes_r;
  logic                 done_r;
  logic                 busy_r;
  word_t                mem_out_r;

  // Step-time snapshot of currents and configuration
  word_t                cur_p0 [N_NEURONS];
  word_t                thr_p0;
  logic                 leak_mode_p0;
  logic                 reset_mode_p0;

`ifdef LIF_REFRACTORY_EN
  logic [RC_W-1:0]      refr_cnt [N_NEURONS];
`endif

  word_t v_cur_p0;
  word_t leak_p0;
  word_t v_leak_p0;
  word_t s_p0;
  logic  fire_p0;
  logic  refr_p0;
  word_t v_next_p0;

  assign bus.spikes  = spikes_r;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
  assign bus.mem_out = mem_out_r;

  // Shared datapath: leak, integrate, saturate and fire for neuron idx.
  always_comb begin
    v_cur_p0  = mem_v[idx];
    leak_p0   = leak_of(v_cur_p0, leak_mode_p0);
    v_leak_p0 = v_cur_p0 - leak_p0;
    s_p0      = sat_add(v_leak_p0, cur_p0[idx]);
    refr_p0   = 1'b0;
`ifdef LIF_REFRACTORY_EN
    refr_p0   = (refr_cnt[idx] != '0);
`endif
    fire_p0   = !refr_p0 && (s_p0 >= thr_p0);
    if (refr_p0)      v_next_p0 = v_leak_p0;
    else if (fire_p0) v_next_p0 = reset_mode_p0 ? (s_p0 - thr_p0) : '0;
    else              v_next_p0 = s_p0;
  end

  // Step sequencer, membrane array and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      spikes_r  <= '0;
      spike_acc <= '0;
      mem_out_r <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        mem_v[k] <= '0;
`ifdef LIF_REFRACTORY_EN
        refr_cnt[k] <= '0;
`endif
      end
    end else begin
      done_r    <= 1'b0;
      mem_out_r <= (int'(bus.mem_sel) < N_NEURONS) ? mem_v[bus.mem_sel] : '0;
      case (state)
        IDLE: begin
          if (bus.step) begin
            for (int k = 0; k < N_NEURONS; k++)
              cur_p0[k] <= bus.in_current[k*WIDTH +: WIDTH];
            thr_p0        <= bus.threshold;
            leak_mode_p0  <= bus.leak_mode;
            reset_mode_p0 <= bus.reset_mode;
            idx           <= '0;
            busy_r        <= 1'b1;
            state         <= UPDATE;
          end
        end
        UPDATE: begin
          mem_v[idx]     <= v_next_p0;
          spike_acc[idx] <= fire_p0;
`ifdef LIF_REFRACTORY_EN
          if (refr_p0)      refr_cnt[idx] <= refr_cnt[idx] - RC_W'(1);
          else if (fire_p0) refr_cnt[idx] <= RC_W'(REFRACT_STEPS);
`endif
          if (idx == SEL_W'(N_NEURONS - 1)) state <= DONE;
          else                              idx   <= idx + SEL_W'(1);
        end
        DONE: begin
          spikes_r <= spike_acc;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
